// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU
// functions, condition codes, register IDs and CC bit positions.
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        A_ADD = 4'h0,
        A_SUB = 4'h1,
        A_AND = 4'h2,
        A_XOR = 4'h3,
        A_MUL = 4'h4
    } alu_fun_e;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'h0,
        C_LE     = 4'h1,
        C_L      = 4'h2,
        C_E      = 4'h3,
        C_NE     = 4'h4,
        C_GE     = 4'h5,
        C_G      = 4'h6
    } cond_e;

    localparam logic [3:0]  REG_NONE   = 4'hF;

    // Condition-code vector is {ZF,SF,OF}
    localparam int unsigned CC_ZF      = 2;
    localparam int unsigned CC_SF      = 1;
    localparam int unsigned CC_OF      = 0;
    localparam logic [2:0]  CC_RESET   = 3'b100;

    // Stack pointer adjustment for call/push/ret/pop
    localparam logic [63:0] STACK_STEP = 64'd8;

    // Registered E/M stage contents
    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_stage_t;

    localparam m_stage_t M_BUBBLE = '{
        valid: 1'b0,
        icode: I_NOP,
        cnd:   1'b0,
        valE:  64'd0,
        valA:  64'd0,
        dstE:  REG_NONE,
        dstM:  REG_NONE
    };

    // Branch / conditional-move condition against a CC snapshot
    function automatic logic cond_eval(input logic [2:0] flags, input logic [3:0] ifun);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf = flags[CC_ZF];
        sf = flags[CC_SF];
        of = flags[CC_OF];
        case (ifun)
            C_ALWAYS: res = 1'b1;
            C_LE:     res = (sf ^ of) | zf;
            C_L:      res = sf ^ of;
            C_E:      res = zf;
            C_NE:     res = !zf;
            C_GE:     res = !(sf ^ of);
            C_G:      res = !(sf ^ of) & !zf;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_64bit.sv
// Combinational 64-bit Y86-64 ALU with {ZF,SF,OF} flag generation.
// Subtraction computes b - a; unknown function codes add.
module alu_64bit
    import y86_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  fun,
    output logic [63:0] result,
    output logic [2:0]  flags
);

    logic ovf;

    // Select the operation and derive the flags from its result
    always_comb begin
        result = b + a;
        ovf    = 1'b0;
        case (fun)
            A_SUB: begin
                result = b - a;
                ovf    = (a[63] != b[63]) && (result[63] != b[63]);
            end
            A_AND: result = b & a;
            A_XOR: result = b ^ a;
            default: begin
                result = b + a;
                ovf    = (a[63] == b[63]) && (result[63] != a[63]);
            end
        endcase
        flags        = '0;
        flags[CC_ZF] = (result == '0);
        flags[CC_SF] = result[63];
        flags[CC_OF] = ovf;
    end

endmodule

// File: rtl/execute_pipe.sv
// Y86-64 execute stage with condition codes and the E/M pipeline register.
// Optional EXEC_MUL_EN adds mulq (OPq ifun 4) as a 64-cycle shift-add
// sequence; without it ifun 4 is an add and e_busy stays low.
module execute_pipe
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        E_valid,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [63:0] E_valC,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic        cc_inhibit,
    output logic        e_busy,
    output logic        M_valid,
    output logic [3:0]  M_icode,
    output logic        M_cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [2:0]  cc
);

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_fun;
    logic [63:0] alu_result;
    logic [2:0]  alu_flags;
    logic        e_cnd;
    logic [3:0]  e_dst_e;
    logic        cc_load_e;
    logic [2:0]  cc_q;
    m_stage_t    m_q;
    m_stage_t    e_to_m;

    // Operand and function selection by instruction class
    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:              alu_a = '0 - STACK_STEP;
            I_RET, I_POPQ:                alu_a = STACK_STEP;
            default:                      alu_a = '0;
        endcase
        alu_b   = (E_icode == I_RRMOVQ || E_icode == I_IRMOVQ) ? '0 : E_valB;
        alu_fun = (E_icode == I_OPQ) ? E_ifun : A_ADD;
    end

    alu_64bit u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fun    (alu_fun),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign e_cnd   = cond_eval(cc_q, E_ifun);
    assign e_dst_e = (E_icode == I_RRMOVQ && !e_cnd) ? REG_NONE : E_dstE;

    // Values a single-cycle instruction presents to the E/M register
    always_comb begin
        e_to_m       = M_BUBBLE;
        e_to_m.valid = 1'b1;
        e_to_m.icode = E_icode;
        e_to_m.cnd   = e_cnd;
        e_to_m.valE  = alu_result;
        e_to_m.valA  = E_valA;
        e_to_m.dstE  = e_dst_e;
        e_to_m.dstM  = E_dstM;
    end

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mul_state_e;

    mul_state_e  state;
    mul_state_e  state_next;
    logic        mul_op;
    logic        mul_start;
    logic        mul_done;
    logic        mul_retire;
    logic [63:0] mul_acc;
    logic [63:0] mul_cand;
    logic [63:0] mul_plier;
    logic [5:0]  mul_cnt;
    logic [63:0] mul_val_a;
    logic [3:0]  mul_dst_e;
    logic [3:0]  mul_dst_m;
    logic        mul_cnd;
    logic [2:0]  mul_flags;
    m_stage_t    mul_to_m;

    // A mulq is only taken when the E/M register would otherwise consume it
    assign mul_op     = (E_icode == I_OPQ) && (E_ifun == A_MUL);
    assign mul_start  = (state == S_IDLE) && E_valid && mul_op && !M_bubble && !M_stall;
    assign mul_done   = (state == S_DONE);
    assign mul_retire = mul_done && !M_bubble && !M_stall;
    // While DONE retires the product, the E input is not executed
    assign cc_load_e  = E_valid && (E_icode == I_OPQ) && !cc_inhibit && !e_busy
                        && !mul_op && !mul_done;

    // Multiplier sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next state and busy indication
    always_comb begin
        state_next = state;
        e_busy     = 1'b0;
        case (state)
            S_IDLE: begin
                if (mul_start) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                e_busy = 1'b1;
                if (mul_cnt == 6'd63) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (M_bubble || !M_stall) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Shift-add datapath: one multiplier bit per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc   <= '0;
            mul_cand  <= '0;
            mul_plier <= '0;
            mul_cnt   <= '0;
            mul_val_a <= '0;
            mul_dst_e <= REG_NONE;
            mul_dst_m <= REG_NONE;
            mul_cnd   <= 1'b0;
        end else if (mul_start) begin
            mul_acc   <= '0;
            mul_cand  <= E_valB;
            mul_plier <= E_valA;
            mul_cnt   <= '0;
            mul_val_a <= E_valA;
            mul_dst_e <= E_dstE;
            mul_dst_m <= E_dstM;
            mul_cnd   <= e_cnd;
        end else if (state == S_BUSY) begin
            if (mul_plier[0]) begin
                mul_acc <= mul_acc + mul_cand;
            end
            mul_cand  <= mul_cand << 1;
            mul_plier <= mul_plier >> 1;
            mul_cnt   <= mul_cnt + 6'd1;
        end
    end

    // Product flags and E/M contents for the retiring mulq
    always_comb begin
        mul_flags        = '0;
        mul_flags[CC_ZF] = (mul_acc == '0);
        mul_flags[CC_SF] = mul_acc[63];
        mul_to_m         = M_BUBBLE;
        mul_to_m.valid   = 1'b1;
        mul_to_m.icode   = I_OPQ;
        mul_to_m.cnd     = mul_cnd;
        mul_to_m.valE    = mul_acc;
        mul_to_m.valA    = mul_val_a;
        mul_to_m.dstE    = mul_dst_e;
        mul_to_m.dstM    = mul_dst_m;
    end
`else
    assign e_busy    = 1'b0;
    assign cc_load_e = E_valid && (E_icode == I_OPQ) && !cc_inhibit && !e_busy;
`endif

    // Condition codes: OPq results, or the product when a mulq retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end
`ifdef EXEC_MUL_EN
        else if (mul_retire && !cc_inhibit) begin
            cc_q <= mul_flags;
        end
`endif
        else if (cc_load_e) begin
            cc_q <= alu_flags;
        end
    end

    // E/M register: bubble beats stall/busy hold, which beats load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= M_BUBBLE;
        end else if (M_bubble) begin
            m_q <= M_BUBBLE;
        end else if (M_stall || e_busy) begin
            m_q <= m_q;
        end
`ifdef EXEC_MUL_EN
        else if (mul_done) begin
            m_q <= mul_to_m;
        end else if (mul_start) begin
            // The mulq leaves E into the sequencer, so M sees a bubble now
            m_q <= M_BUBBLE;
        end
`endif
        else if (!E_valid) begin
            m_q <= M_BUBBLE;
        end else begin
            m_q <= e_to_m;
        end
    end

    assign M_valid = m_q.valid;
    assign M_icode = m_q.icode;
    assign M_cnd   = m_q.cnd;
    assign M_valE  = m_q.valE;
    assign M_valA  = m_q.valA;
    assign M_dstE  = m_q.dstE;
    assign M_dstM  = m_q.dstM;
    assign cc      = cc_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed self-checking bench for execute_pipe; mulq scenarios are built
// only when EXEC_MUL_EN is defined.
module tb_execute_pipe;

    logic        clk;
    logic        rst;
    logic        E_valid;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [63:0] E_valC;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic        M_stall;
    logic        M_bubble;
    logic        cc_inhibit;
    logic        e_busy;
    logic        M_valid;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [2:0]  cc;

    int vectors;
    int miscompares;

    execute_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .E_valid    (E_valid),
        .E_icode    (E_icode),
        .E_ifun     (E_ifun),
        .E_valA     (E_valA),
        .E_valB     (E_valB),
        .E_valC     (E_valC),
        .E_dstE     (E_dstE),
        .E_dstM     (E_dstM),
        .M_stall    (M_stall),
        .M_bubble   (M_bubble),
        .cc_inhibit (cc_inhibit),
        .e_busy     (e_busy),
        .M_valid    (M_valid),
        .M_icode    (M_icode),
        .M_cnd      (M_cnd),
        .M_valE     (M_valE),
        .M_valA     (M_valA),
        .M_dstE     (M_dstE),
        .M_dstM     (M_dstM),
        .cc         (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] de, input logic [3:0] dm);
        E_valid = v;
        E_icode = ic;
        E_ifun  = fn;
        E_valA  = a;
        E_valB  = b;
        E_valC  = c;
        E_dstE  = de;
        E_dstM  = dm;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({cc, M_valid, M_icode, M_cnd, M_dstE, M_dstM, e_busy} !== {3'b100, 1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %h expected %h", {cc, M_valid, M_icode, M_cnd, M_dstE, M_dstM, e_busy},
                     {3'b100, 1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 1'b0});
        end
        vectors++;
        if ({M_valE, M_valA} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected %h", {M_valE, M_valA}, 128'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_overflow;
        drive(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, 4'hF);
        tick();
        vectors++;
        if ({M_valid, M_icode, M_cnd, M_valE, M_dstE} !== {1'b1, 4'h6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'h1}) begin
            miscompares++;
            $display("FAIL add_ovf_m: got %h expected %h", {M_valid, M_icode, M_cnd, M_valE, M_dstE},
                     {1'b1, 4'h6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'h1});
        end
        vectors++;
        if (cc !== 3'b011) begin
            miscompares++;
            $display("FAIL add_ovf_cc: got %b expected %b", cc, 3'b011);
        end
    endtask

    task automatic test_sub_zero;
        drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF);
        tick();
        vectors++;
        if ({M_valE, cc} !== {64'd0, 3'b100}) begin
            miscompares++;
            $display("FAIL sub_zero: got %h expected %h", {M_valE, cc}, {64'd0, 3'b100});
        end
    endtask

    task automatic test_logic_ops;
        drive(1'b1, 4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0, 4'h3, 4'hF);
        tick();
        vectors++;
        if ({M_valE, cc} !== {64'hF000, 3'b000}) begin
            miscompares++;
            $display("FAIL and_op: got %h expected %h", {M_valE, cc}, {64'hF000, 3'b000});
        end
        drive(1'b1, 4'h6, 4'h3, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 4'h3, 4'hF);
        tick();
        vectors++;
        if ({M_valE, cc} !== {64'h8000_0000_0000_0000, 3'b010}) begin
            miscompares++;
            $display("FAIL xor_op: got %h expected %h", {M_valE, cc}, {64'h8000_0000_0000_0000, 3'b010});
        end
        drive(1'b1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h3, 4'hF);
        tick();
        vectors++;
        if ({M_valE, cc} !== {64'h7FFF_FFFF_FFFF_FFFF, 3'b001}) begin
            miscompares++;
            $display("FAIL sub_ovf: got %h expected %h", {M_valE, cc}, {64'h7FFF_FFFF_FFFF_FFFF, 3'b001});
        end
    endtask

    task automatic test_cmov;
        drive(1'b1, 4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h1, 4'hF);
        tick();
        vectors++;
        if (cc !== 3'b010) begin
            miscompares++;
            $display("FAIL cmov_setup_cc: got %b expected %b", cc, 3'b010);
        end
        drive(1'b1, 4'h2, 4'h2, 64'h55, 64'h999, 64'd0, 4'h3, 4'hF);
        tick();
        vectors++;
        if ({M_cnd, M_dstE, M_valE, cc} !== {1'b1, 4'h3, 64'h55, 3'b010}) begin
            miscompares++;
            $display("FAIL cmov_taken: got %h expected %h", {M_cnd, M_dstE, M_valE, cc}, {1'b1, 4'h3, 64'h55, 3'b010});
        end
        drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1, 4'hF);
        tick();
        drive(1'b1, 4'h2, 4'h2, 64'h55, 64'h999, 64'd0, 4'h3, 4'hF);
        tick();
        vectors++;
        if ({M_cnd, M_dstE, cc} !== {1'b0, 4'hF, 3'b100}) begin
            miscompares++;
            $display("FAIL cmov_not_taken: got %h expected %h", {M_cnd, M_dstE, cc}, {1'b0, 4'hF, 3'b100});
        end
    endtask

    task automatic test_push_inhibit;
        drive(1'b1, 4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF);
        tick();
        vectors++;
        if ({M_valE, M_valA, M_dstE, cc} !== {64'hF8, 64'h77, 4'h4, 3'b100}) begin
            miscompares++;
            $display("FAIL push: got %h expected %h", {M_valE, M_valA, M_dstE, cc}, {64'hF8, 64'h77, 4'h4, 3'b100});
        end
        cc_inhibit = 1'b1;
        drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF);
        tick();
        cc_inhibit = 1'b0;
        vectors++;
        if ({M_valE, cc} !== {64'd2, 3'b100}) begin
            miscompares++;
            $display("FAIL cc_inhibit: got %h expected %h", {M_valE, cc}, {64'd2, 3'b100});
        end
    endtask

    task automatic test_addr_modes;
        drive(1'b1, 4'h5, 4'h0, 64'd0, 64'h200, 64'h10, 4'hF, 4'h6);
        tick();
        vectors++;
        if ({M_valE, M_dstM} !== {64'h210, 4'h6}) begin
            miscompares++;
            $display("FAIL mrmovq: got %h expected %h", {M_valE, M_dstM}, {64'h210, 4'h6});
        end
        drive(1'b1, 4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'hF);
        tick();
        vectors++;
        if (M_valE !== 64'h108) begin
            miscompares++;
            $display("FAIL ret: got %h expected %h", M_valE, 64'h108);
        end
        drive(1'b1, 4'h3, 4'h0, 64'd0, 64'h999, 64'h1234, 4'h5, 4'hF);
        tick();
        vectors++;
        if ({M_valE, M_dstE} !== {64'h1234, 4'h5}) begin
            miscompares++;
            $display("FAIL irmovq: got %h expected %h", {M_valE, M_dstE}, {64'h1234, 4'h5});
        end
    endtask

    task automatic test_stall_bubble;
        M_stall = 1'b1;
        drive(1'b1, 4'h3, 4'h0, 64'd0, 64'd0, 64'hAAAA, 4'h7, 4'hF);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({M_valid, M_valE, M_dstE} !== {1'b1, 64'h1234, 4'h5}) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, {M_valid, M_valE, M_dstE}, {1'b1, 64'h1234, 4'h5});
            end
        end
        M_bubble = 1'b1;
        tick();
        vectors++;
        if ({M_valid, M_icode, M_dstE, M_valE} !== {1'b0, 4'h1, 4'hF, 64'd0}) begin
            miscompares++;
            $display("FAIL stall_plus_bubble: got %h expected %h", {M_valid, M_icode, M_dstE, M_valE}, {1'b0, 4'h1, 4'hF, 64'd0});
        end
        M_stall  = 1'b0;
        M_bubble = 1'b0;
    endtask

    task automatic test_bubble_input;
        drive(1'b1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h42, 4'h1, 4'hF);
        tick();
        drive(1'b0, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF);
        tick();
        vectors++;
        if ({M_valid, M_icode, M_valE, cc} !== {1'b0, 4'h1, 64'd0, 3'b100}) begin
            miscompares++;
            $display("FAIL bubble_in: got %h expected %h", {M_valid, M_icode, M_valE, cc}, {1'b0, 4'h1, 64'd0, 3'b100});
        end
    endtask

`ifdef EXEC_MUL_EN
    task automatic test_mul;
        int n;
        logic seen_valid;
        drive(1'b1, 4'h6, 4'h4, 64'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 4'h2, 4'hF);
        tick();
        vectors++;
        if ({e_busy, M_valid} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mul_capture: got %b expected %b", {e_busy, M_valid}, 2'b10);
        end
        drive(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        n = 0;
        while (e_busy && n < 200) begin
            n++;
            tick();
        end
        vectors++;
        if (n !== 64) begin
            miscompares++;
            $display("FAIL mul_busy_cycles: got %0d expected %0d", n, 64);
        end
        tick();
        vectors++;
        if ({M_valid, M_icode, M_valE, M_dstE, cc} !== {1'b1, 4'h6, 64'hFFFF_FFFF_FFFF_FFEB, 4'h2, 3'b010}) begin
            miscompares++;
            $display("FAIL mul_result: got %h expected %h", {M_valid, M_icode, M_valE, M_dstE, cc},
                     {1'b1, 4'h6, 64'hFFFF_FFFF_FFFF_FFEB, 4'h2, 3'b010});
        end
        drive(1'b1, 4'h6, 4'h4, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF);
        tick();
        drive(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({e_busy, M_valid, cc} !== {1'b0, 1'b0, 3'b100}) begin
            miscompares++;
            $display("FAIL mul_abort: got %b expected %b", {e_busy, M_valid, cc}, 5'b00100);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (80) begin
            tick();
            if (M_valid || e_busy) seen_valid = 1'b1;
        end
        vectors++;
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_abort_leak: got %b expected %b", seen_valid, 1'b0);
        end
    endtask
`else
    task automatic test_ifun4_add;
        drive(1'b1, 4'h6, 4'h4, 64'd3, 64'd4, 64'd0, 4'h2, 4'hF);
        tick();
        vectors++;
        if ({M_valE, cc, e_busy} !== {64'd7, 3'b000, 1'b0}) begin
            miscompares++;
            $display("FAIL ifun4_add: got %h expected %h", {M_valE, cc, e_busy}, {64'd7, 3'b000, 1'b0});
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        M_stall     = 1'b0;
        M_bubble    = 1'b0;
        cc_inhibit  = 1'b0;
        drive(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_logic_ops();
        test_cmov();
        test_push_inhibit();
        test_addr_modes();
        test_stall_bubble();
        test_bubble_input();
`ifdef EXEC_MUL_EN
        test_mul();
`else
        test_ifun4_add();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous reset, active-high.
REQ-003 E_valid  in  1  E-stage holds a real instruction; 0 means bubble.
REQ-004 E_icode, E_ifun  in  4 each  Y86-64 opcode/function.
REQ-005 E_valA, E_valB, E_valC  in  64 each  operands from decode/fetch.
REQ-006 E_dstE, E_dstM  in  4 each  destination register IDs; 4'hF = none.
REQ-007 M_stall, M_bubble  in  1 each  hazard-unit controls for the E/M register.
REQ-008 cc_inhibit  in  1  exception in M/W; blocks CC update this cycle.
REQ-009 e_busy  out  1  execute cannot accept a new instruction (multi-cycle op in flight).
REQ-010 M_valid, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  1/4/1/64/64/4/4  registered E/M stage outputs.
REQ-011 cc  out  3  registered condition codes {ZF,SF,OF}.

Function
REQ-012 aluA SHALL be valA for rrmovq/OPq(2,6); valC for irmovq/rmmovq/mrmovq(3,4,5); -8 for call/push(8,A); +8 for ret/pop(9,B).
REQ-013 aluB SHALL be valB, except 0 for rrmovq/irmovq.
REQ-014 ALU fun SHALL be E_ifun for OPq (0 add, 1 sub = aluB-aluA, 2 and, 3 xor), add otherwise; results are 64-bit, wrap-around, two's complement.
REQ-015 New ZF = (result==0); SF = result[63]; OF: add = operands same sign, result differs; sub = aluB,aluA differ in sign and result sign != aluB sign; and/xor = 0.
REQ-016 cc SHALL load new flags on the rising edge only when E_valid, E_icode==6, !cc_inhibit, !e_busy; otherwise hold.
REQ-017 cnd SHALL evaluate current cc (pre-update) per ifun: 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF, 5 ge !(SF^OF), 6 g !(SF^OF)&!ZF; ifun 7-F gives 0.
REQ-018 For cmovXX (icode 2) with cnd=0, M_dstE SHALL be 4'hF.
REQ-019 E/M register priority each edge: M_bubble -> load bubble (M_valid=0, M_icode=1 nop, dstE/dstM=F, M_cnd=0, data 0); else M_stall or e_busy -> hold; else load E values, M_valA=E_valA.
REQ-020 M_bubble and M_stall together SHALL resolve as bubble.
REQ-021 Bubble input (E_valid=0) SHALL propagate as bubble, with cc unchanged.
REQ-022 Latency: single-cycle ops visible at M outputs one clock after capture.

Reset
REQ-023 rst SHALL force immediately: cc=3'b100 (ZF=1), M register to bubble state, e_busy=0, FSM IDLE.
REQ-024 rst during a multi-cycle op SHALL abort it; no partial result reaches M.

Configuration
REQ-025 Macro EXEC_MUL_EN SHALL add OPq ifun 4 (mulq, low 64 bits of valB*valA) via a shift-add FSM IDLE->BUSY (64 cycles)->DONE->IDLE.
REQ-026 With EXEC_MUL_EN: e_busy=1 from the cycle after capture through BUSY; DONE loads M and cc (ZF/SF from product, OF=0) in one cycle; M_bubble during BUSY bubbles M but the multiply continues.
REQ-027 Without EXEC_MUL_EN: ifun 4 behaves as add; e_busy is constant 0; no FSM exists.

Structure
REQ-028 Shared package y86_pkg SHALL hold icode/ifun/cond encodings, REG_NONE=4'hF, and CC bit positions.
REQ-029 Sub-module alu_64bit (combinational ALU + flag generation) is instantiated once; the multiplier FSM stays in execute_pipe.

Verification
REQ-030 OPq sub, valA=5, valB=5 -> next edge M_valE=0, cc=3'b100.
REQ-031 OPq add, valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> M_valE=64'hFFFF_FFFF_FFFF_FFFE, cc=3'b011.
REQ-032 cmovl (2,2) with cc SF=1,OF=0, dstE=3 -> M_cnd=1, M_dstE=3; cc=3'b100 -> M_dstE=F.
REQ-033 push, valB=64'h100 -> M_valE=64'hF8, cc unchanged; same with cc_inhibit on OPq -> cc unchanged.
REQ-034 M_stall and M_bubble both high -> M_valid=0; stall alone holds M values two cycles.
REQ-035 EXEC_MUL_EN: mulq valA=3, valB=-7 -> e_busy high 64 cycles, M_valE=-21, cc=3'b010; rst mid-op -> bubble, e_busy=0.
